id_ex_stage: RTL and testbench

ID/EX pipeline stage that registers one decoded instruction and presents ALU operands `a`, `b` and `sel` to the `alu` in EX. It uses a valid/ready handshake with back-pressure, flush, and optional EX/MEM and MEM/WB operand forwarding. It sits between the register-file/decode stage (upstream) and the `alu` (downstream).

---
 rtl/id_ex_stage_if.sv | 48 ++++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side handshake and slot inputs, forwarding inputs and ALU-side outputs.
// master drives the decode/forwarding side; slave is the id_ex_stage itself.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    // valid/ready: a transfer happens on a rising clk edge where valid && ready are both 1;
    // a producer holding valid keeps its payload stable until that edge.
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] rsData;
    logic [WIDTH-1:0] rtData;
    logic [WIDTH-1:0] immExt;
    logic             aluSrc;
    logic [1:0]       aluSel;
    logic [RADDR-1:0] rsAddr;
    logic [RADDR-1:0] rtAddr;
    logic [RADDR-1:0] rdAddr;
    logic             regWrite;
    logic             flush;
    logic             exMemRegWrite;
    logic [RADDR-1:0] exMemRd;
    logic [WIDTH-1:0] exMemResult;
    logic             memWbRegWrite;
    logic [RADDR-1:0] memWbRd;
    logic [WIDTH-1:0] memWbResult;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic [RADDR-1:0] rdOut;
    logic             regWriteOut;

    modport master (
        output inValid, rsData, rtData, immExt, aluSrc, aluSel, rsAddr, rtAddr, rdAddr,
               regWrite, flush, exMemRegWrite, exMemRd, exMemResult, memWbRegWrite,
               memWbRd, memWbResult, outReady,
        input  inReady, outValid, a, b, sel, rdOut, regWriteOut
    );

    modport slave (
        input  inValid, rsData, rtData, immExt, aluSrc, aluSel, rsAddr, rtAddr, rdAddr,
               regWrite, flush, exMemRegWrite, exMemRd, exMemResult, memWbRegWrite,
               memWbRd, memWbResult, outReady,
        output inReady, outValid, a, b, sel, rdOut, regWriteOut
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-slot skid-free stage presenting ALU operands with flush support.
// Define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding onto a/b.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic             alu_src;
        logic [1:0]       alu_sel;
        logic [RADDR-1:0] rs_addr;
        logic [RADDR-1:0] rt_addr;
        logic [RADDR-1:0] rd_addr;
        logic             reg_write;
    } slot_t;

    slot_t slot_q, slot_d;
    logic  valid_q, valid_d;
    logic  in_ready;
    logic  accept;

    assign in_ready = !valid_q || bus.outReady;
    assign accept   = bus.inValid && in_ready;

    // Flush wins over an accept in the same cycle: the incoming instruction is on the wrong path.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d           = 1'b1;
            slot_d.rs_data    = bus.rsData;
            slot_d.rt_data    = bus.rtData;
            slot_d.imm        = bus.immExt;
            slot_d.alu_src    = bus.aluSrc;
            slot_d.alu_sel    = bus.aluSel;
            slot_d.rs_addr    = bus.rsAddr;
            slot_d.rt_addr    = bus.rtAddr;
            slot_d.rd_addr    = bus.rdAddr;
            slot_d.reg_write  = bus.regWrite;
        end else if (bus.outReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] rt_val;

`ifdef ID_EX_FORWARDING_EN
    logic ex_hit_rs, wb_hit_rs, ex_hit_rt, wb_hit_rt;

    // Register 0 is hard-wired, so a write-back naming it must never override the operand.
    assign ex_hit_rs = bus.exMemRegWrite && (bus.exMemRd == slot_q.rs_addr) && (slot_q.rs_addr != '0);
    assign wb_hit_rs = bus.memWbRegWrite && (bus.memWbRd == slot_q.rs_addr) && (slot_q.rs_addr != '0);
    assign ex_hit_rt = bus.exMemRegWrite && (bus.exMemRd == slot_q.rt_addr) && (slot_q.rt_addr != '0);
    assign wb_hit_rt = bus.memWbRegWrite && (bus.memWbRd == slot_q.rt_addr) && (slot_q.rt_addr != '0);

    always_comb begin
        a_val = slot_q.rs_data;
        if (ex_hit_rs)      a_val = bus.exMemResult;
        else if (wb_hit_rs) a_val = bus.memWbResult;
        rt_val = slot_q.rt_data;
        if (ex_hit_rt)      rt_val = bus.exMemResult;
        else if (wb_hit_rt) rt_val = bus.memWbResult;
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{bus.exMemRegWrite, bus.exMemRd, bus.exMemResult,
                          bus.memWbRegWrite, bus.memWbRd, bus.memWbResult,
                          slot_q.rs_addr, slot_q.rt_addr};
    assign a_val  = slot_q.rs_data;
    assign rt_val = slot_q.rt_data;
`endif

    assign bus.inReady     = in_ready;
    assign bus.outValid    = valid_q;
    assign bus.a           = a_val;
    assign bus.b           = slot_q.alu_src ? slot_q.imm : rt_val;
    assign bus.sel         = slot_q.alu_sel;
    assign bus.rdOut       = slot_q.rd_addr;
    assign bus.regWriteOut = valid_q && slot_q.reg_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus random bench for id_ex_stage with a one-deep expected-instruction queue.
module tb_id_ex_stage;
    localparam int W = 32;
    localparam int R = 5;
`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] imm;
        logic         src;
        logic [1:0]   sel;
        logic [R-1:0] rsa;
        logic [R-1:0] rta;
        logic [R-1:0] rd;
        logic         rw;
    } slot_t;
    localparam int SW = $bits(slot_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(W), .RADDR(R)) bus ();
    id_ex_stage #(.WIDTH(W), .RADDR(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [SW-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fwd(input logic [R-1:0] addr, input logic [W-1:0] dflt);
        if (FWD_EN && bus.exMemRegWrite && bus.exMemRd == addr && addr != 0) return bus.exMemResult;
        if (FWD_EN && bus.memWbRegWrite && bus.memWbRd == addr && addr != 0) return bus.memWbResult;
        return dflt;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         input logic [W-1:0] imm, input logic src, input logic [1:0] sel,
                         input logic [R-1:0] rsa, input logic [R-1:0] rta,
                         input logic [R-1:0] rd, input logic rw);
        bus.inValid = v;   bus.rsData = rs;  bus.rtData = rt;  bus.immExt = imm;
        bus.aluSrc = src;  bus.aluSel = sel; bus.rsAddr = rsa; bus.rtAddr = rta;
        bus.rdAddr = rd;   bus.regWrite = rw;
    endtask

    task automatic set_fwd(input logic exw, input logic [R-1:0] exrd, input logic [W-1:0] exres,
                           input logic wbw, input logic [R-1:0] wbrd, input logic [W-1:0] wbres);
        bus.exMemRegWrite = exw; bus.exMemRd = exrd; bus.exMemResult = exres;
        bus.memWbRegWrite = wbw; bus.memWbRd = wbrd; bus.memWbResult = wbres;
    endtask

    // Check outputs at the falling edge, then advance the model across the next rising edge.
    task automatic cycle();
        slot_t h;
        slot_t n;
        logic  rdy;
        @(negedge clk);
        rdy = (exp_q.size() == 0) || bus.outReady;
        chk("in_ready", W'(bus.inReady), W'(rdy));
        chk("out_valid", W'(bus.outValid), W'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("a", bus.a, fwd(h.rsa, h.rs));
            chk("b", bus.b, h.src ? h.imm : fwd(h.rta, h.rt));
            chk("sel", W'(bus.sel), W'(h.sel));
            chk("rd_out", W'(bus.rdOut), W'(h.rd));
            chk("reg_write_out", W'(bus.regWriteOut), W'(h.rw));
            if (bus.outReady || bus.flush) void'(exp_q.pop_front());
        end else begin
            chk("reg_write_out_idle", W'(bus.regWriteOut), '0);
        end
        if (bus.inValid && rdy && !bus.flush) begin
            n = '{bus.rsData, bus.rtData, bus.immExt, bus.aluSrc, bus.aluSel,
                  bus.rsAddr, bus.rtAddr, bus.rdAddr, bus.regWrite};
            exp_q.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, '0, '0, '0, 0, 2'b00, '0, '0, '0, 0);
        set_fwd(0, '0, '0, 0, '0, '0);
        bus.flush = 0;
        bus.outReady = 0;
        #2;
        chk("rst_out_valid", W'(bus.outValid), '0);
        chk("rst_in_ready", W'(bus.inReady), W'(1));
        chk("rst_reg_write_out", W'(bus.regWriteOut), '0);
        chk("rst_sel", W'(bus.sel), '0);
        chk("rst_rd_out", W'(bus.rdOut), '0);
        chk("rst_a", bus.a, '0);
        chk("rst_b", bus.b, '0);
        @(posedge clk);
        #1 rst_n = 1;

        // basic pass
        bus.outReady = 1;
        drive(1, 10, 15, 0, 0, 2'b00, 1, 2, 3, 1);
        cycle();
        bus.inValid = 0;
        #3;
        chk("alu_sum", bus.a + bus.b, 25);
        chk("basic_sel", W'(bus.sel), '0);
        cycle();

        // back-to-back throughput
        for (int i = 0; i < 6; i++) begin
            drive(1, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), R'($urandom_range(0, 31)),
                  R'($urandom_range(0, 31)), R'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            cycle();
        end
        bus.inValid = 0;
        cycle();

        // back-pressure with a pending instruction, released with no bubble
        drive(1, 100, 200, 0, 0, 2'b01, 3, 4, 5, 1);
        cycle();
        bus.outReady = 0;
        drive(1, 300, 400, 0, 0, 2'b10, 6, 7, 8, 1);
        for (int i = 0; i < 3; i++) cycle();
        bus.outReady = 1;
        cycle();
        bus.inValid = 0;
        cycle();

        // forwarding priority on a held instruction
        drive(1, 5, 7, 0, 0, 2'b00, 8, 9, 4, 1);
        cycle();
        bus.inValid = 0;
        bus.outReady = 0;
        set_fwd(1, 8, 20, 1, 8, 99);
        #2;
        chk("fwd_exmem", bus.a, FWD_EN ? 32'd20 : 32'd5);
        cycle();
        bus.exMemRegWrite = 0;
        #2;
        chk("fwd_memwb", bus.a, FWD_EN ? 32'd99 : 32'd5);
        cycle();

        // register 0 never forwarded
        set_fwd(0, '0, '0, 0, '0, '0);
        bus.outReady = 1;
        drive(1, 33, 44, 0, 0, 2'b11, 0, 0, 2, 1);
        cycle();
        bus.inValid = 0;
        bus.outReady = 0;
        set_fwd(1, 0, 20, 1, 0, 99);
        #2;
        chk("fwd_r0_a", bus.a, 33);
        chk("fwd_r0_b", bus.b, 44);
        cycle();

        // immediate bypasses forwarding
        set_fwd(0, '0, '0, 0, '0, '0);
        bus.outReady = 1;
        drive(1, 1, 44, 32'hFFFF_FFFC, 1, 2'b00, 1, 6, 2, 1);
        cycle();
        bus.inValid = 0;
        bus.outReady = 0;
        set_fwd(1, 6, 20, 1, 6, 99);
        #2;
        chk("imm_b", bus.b, 32'hFFFF_FFFC);
        cycle();

        // flush while stalled, with a simultaneous incoming instruction
        set_fwd(0, '0, '0, 0, '0, '0);
        bus.flush = 1;
        drive(1, 77, 88, 0, 0, 2'b01, 1, 2, 9, 1);
        cycle();
        bus.flush = 0;
        bus.inValid = 0;
        #2;
        chk("flush_out_valid", W'(bus.outValid), '0);
        chk("flush_reg_write_out", W'(bus.regWriteOut), '0);
        cycle();

        // flush together with consume
        bus.outReady = 1;
        drive(1, 11, 22, 0, 0, 2'b10, 1, 2, 3, 1);
        cycle();
        bus.flush = 1;
        drive(1, 55, 66, 0, 0, 2'b11, 4, 5, 6, 1);
        cycle();
        bus.flush = 0;
        bus.inValid = 0;
        cycle();

        // random traffic with back-pressure, flushes and forwarding hits
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), R'($urandom_range(0, 3)), R'($urandom_range(0, 3)),
                  R'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            bus.outReady = 1'($urandom_range(0, 1));
            bus.flush = ($urandom_range(0, 9) == 0);
            set_fwd(1'($urandom_range(0, 1)), R'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), R'($urandom_range(0, 3)), $urandom);
            cycle();
        end
        bus.flush = 0;
        bus.inValid = 0;
        bus.outReady = 1;
        set_fwd(0, '0, '0, 0, '0, '0);
        cycle();

        // reset while stalled takes effect with no clock edge
        drive(1, 123, 456, 0, 0, 2'b01, 1, 2, 3, 1);
        cycle();
        bus.inValid = 0;
        bus.outReady = 0;
        cycle();
        rst_n = 0;
        #1;
        chk("rst_stall_out_valid", W'(bus.outValid), '0);
        chk("rst_stall_in_ready", W'(bus.inReady), W'(1));
        chk("rst_stall_reg_write_out", W'(bus.regWriteOut), '0);
        chk("rst_stall_a", bus.a, '0);
        chk("rst_stall_b", bus.b, '0);
        exp_q.delete();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
